alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-004 SHALL have ports req0_ready / req1_ready  output  1  operation of requester N accepted this cycle.
REQ-005 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  32  operands of requester N.
REQ-006 SHALL have ports req0_op / req1_op  input  3  ALU opcode of requester N.
REQ-007 SHALL have ports alu_a, alu_b  output  32 and alu_op  output  3  drive the shared external ALU.
REQ-008 SHALL have port alu_c  input  32  combinational result from the shared ALU.
REQ-009 SHALL have ports rsp_valid  output  1, rsp_id  output  1, rsp_data  output  32, rsp_err  output  1  result channel.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP; transitions IDLE->EXEC on accept, EXEC->RESP unconditionally after one cycle, RESP->IDLE on rsp_valid & rsp_ready.
REQ-013 SHALL assert reqN_ready combinationally only in IDLE, only for the granted requester, never both in the same cycle.
REQ-014 SHALL grant, in IDLE: the only valid requester if exactly one is valid; requester ptr if both are valid; none if neither is valid.
REQ-015 SHALL keep a 1-bit round-robin pointer ptr, updated to the non-granted index on each accept.
REQ-016 SHALL latch a, b, op and the granted index into internal registers on the accept edge.
REQ-017 SHALL drive alu_a, alu_b, alu_op from those registers at all times; they are stable throughout EXEC.
REQ-018 SHALL capture alu_c into rsp_data at the end of the EXEC cycle; rsp_data is held unchanged through RESP.
REQ-019 SHALL set rsp_err = 1 when the latched op is 3'b110 or 3'b111; the op is still issued, and rsp_data carries whatever alu_c returns (0 for these codes).
REQ-020 SHALL assert rsp_valid only in RESP; rsp_id, rsp_data and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
REQ-021 SHALL give fixed latency: accept at edge T, rsp_valid high from T+2; peak throughput one operation per 3 cycles.
REQ-022 SHALL not check operand values or shift amounts; the ALU result passes through unmodified (e.g. shift by B>=32 handled by the ALU).
REQ-023 SHALL ignore reqN_valid changes outside IDLE; requesters hold valid and payload until ready.
REQ-024 SHALL, when rsp_ready is already high on entry to RESP, complete the response in one cycle and return to IDLE; a new accept happens on the following cycle, never the same cycle.

Reset
REQ-025 SHALL, on rst_n low, immediately force: state IDLE, ptr 0, operand/op/id registers 0, rsp_data 0, rsp_err 0.
REQ-026 SHALL hold all outputs low while rst_n is low: rsp_valid, busy and reqN_ready at 0; alu_a, alu_b, alu_op at 0.
REQ-027 SHALL discard any in-flight operation when reset asserts mid-EXEC or mid-RESP, with no response issued afterwards.
REQ-028 SHALL resume normal operation on the first rising clk after rst_n deasserts.

Verification
REQ-029 SHALL cover single request: req0 a=5, b=3, op=001, rsp_ready=1.
  Required: req0_ready for 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=2, rsp_err=0.
REQ-030 SHALL cover contention: both valid from reset, req0 op=000 (1+1), req1 op=010 (0xF0 & 0x3C).
  Required: req0 granted first (data 2); req1 granted next (data 0x30, id 1); order alternates while both stay valid.
REQ-031 SHALL cover backpressure: rsp_ready=0 for 5 cycles in RESP with req1 valid.
  Required: rsp_valid and rsp_data held stable; req1_ready stays 0 until the response completes.
REQ-032 SHALL cover illegal opcode: req1 op=111, a=0xFFFFFFFF, b=1.
  Required: rsp_data=0, rsp_err=1, rsp_id=1.
REQ-033 SHALL cover arithmetic shift: req0 a=0x80000000, b=4, op=101.
  Required: rsp_data=0xF8000000.
REQ-034 SHALL cover reset mid-operation: rst_n pulsed low during EXEC.
  Required: rsp_valid and busy drop immediately; no response after release; the next req1 request is accepted normally with ptr=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end sharing one external combinational ALU.
// Latency: accept at edge T, operands on alu_* during EXEC, rsp_valid asserted from the cycle after EXEC.
// Backpressure: result held in RESP until rsp_ready; no new request is accepted until back in IDLE.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_c,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        rsp_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        id_q, id_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        gnt0, gnt1;

  // Grant in IDLE only: a lone valid requester wins, on contention ptr picks; gated by rst_n so
  // ready stays low while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      gnt0 = req0_valid && (!req1_valid || !ptr_q);
      gnt1 = req1_valid && (!req0_valid ||  ptr_q);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Next-state and datapath capture: latch the winner on accept, sample the ALU at the end of EXEC.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          state_d = EXEC;
          // Pointer moves to the requester that lost this round.
          ptr_d   = gnt0;
          a_d     = gnt1 ? req1_a  : req0_a;
          b_d     = gnt1 ? req1_b  : req0_b;
          op_d    = gnt1 ? req1_op : req0_op;
          id_d    = gnt1;
        end
      end
      EXEC: begin
        state_d = RESP;
        data_d  = alu_c;
        // Codes 110/111 are still issued to the ALU but flagged as errors.
        err_d   = (op_q[2:1] == 2'b11);
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      id_q    <= 1'b0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the shared ALU, scoreboards every accepted operation,
// runs a table of single-requester vectors plus contention, backpressure and reset sequences.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_op;
  logic        rsp_valid, rsp_id, rsp_err, busy;
  logic [31:0] rsp_data;
  logic        rsp_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Reference ALU: 000 add, 001 sub, 010 and, 011 or, 100 sll, 101 sra, 110/111 return 0.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    case (op)
      3'b000:  alu_model = a + b;
      3'b001:  alu_model = a - b;
      3'b010:  alu_model = a & b;
      3'b011:  alu_model = a | b;
      3'b100:  alu_model = a << b;
      3'b101:  alu_model = 32'($signed(a) >>> b);
      default: alu_model = 32'd0;
    endcase
  endfunction

  assign alu_c = alu_model(alu_a, alu_b, alu_op);

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic note_fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Scoreboard entries are pushed on accept and popped on response handshake.
  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic        id_log[$];
  int          cyc = 0;
  int          acc0_cnt = 0, acc1_cnt = 0, rsp_cnt = 0;
  int          acc1_cyc = 0, rsp_cyc = 0;
  logic        last_id = 1'b0, last_err = 1'b0;
  logic [31:0] last_data = '0;
  logic        prev_vld = 1'b0, prev_rdy = 1'b0;
  logic        hold_id = 1'b0, hold_err = 1'b0;
  logic [31:0] hold_data = '0;

  // Monitor on the falling edge, where inputs and combinational outputs are settled.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      prev_vld = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      if (req0_ready || req1_ready) begin
        chk("one_grant", 32'(req0_ready & req1_ready), 32'd0);
        chk("ready_only_idle", 32'(busy), 32'd0);
      end
      if (req0_ready && req0_valid) begin
        e = '{id: 1'b0, data: alu_model(req0_a, req0_b, req0_op), err: (req0_op[2:1] == 2'b11), acc: cyc};
        sb.push_back(e);
        acc0_cnt++;
      end
      if (req1_ready && req1_valid) begin
        e = '{id: 1'b1, data: alu_model(req1_a, req1_b, req1_op), err: (req1_op[2:1] == 2'b11), acc: cyc};
        sb.push_back(e);
        acc1_cnt++;
        acc1_cyc = cyc;
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          note_fail("rsp_unexpected: rsp_valid with no outstanding operation");
        end else begin
          if (!prev_vld) chk("latency", 32'(cyc), 32'(sb[0].acc + 2));
          else if (!prev_rdy) begin
            chk("hold_data", rsp_data, hold_data);
            chk("hold_id", 32'(rsp_id), 32'(hold_id));
            chk("hold_err", 32'(rsp_err), 32'(hold_err));
          end
          if (rsp_ready) begin
            e = sb.pop_front();
            chk("sb_id", 32'(rsp_id), 32'(e.id));
            chk("sb_data", rsp_data, e.data);
            chk("sb_err", 32'(rsp_err), 32'(e.err));
            id_log.push_back(rsp_id);
            last_id   = rsp_id;
            last_data = rsp_data;
            last_err  = rsp_err;
            rsp_cyc   = cyc;
            rsp_cnt++;
          end
        end
        hold_id   = rsp_id;
        hold_data = rsp_data;
        hold_err  = rsp_err;
      end
      prev_vld = rsp_valid;
      prev_rdy = rsp_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic v);
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = v;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = v;
    end
  endtask

  task automatic wait_acc(input logic id);
    int  c0;
    bit  got;
    c0  = id ? acc1_cnt : acc0_cnt;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      got = ((id ? acc1_cnt : acc0_cnt) != c0);
    end
    if (!got) note_fail("accept_timeout");
  endtask

  task automatic wait_rsp(input int target);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = (rsp_cnt >= target);
    end
    if (!got) note_fail("response_timeout");
  endtask

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vt[9];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int r0;
    int a0;
    int tot;
    bit got;

    vt[0] = '{1'b0, 32'd5,        32'd3,         3'b001, 32'd2,        1'b0};
    vt[1] = '{1'b1, 32'hFFFFFFFF, 32'd1,         3'b111, 32'd0,        1'b1};
    vt[2] = '{1'b0, 32'h80000000, 32'd4,         3'b101, 32'hF8000000, 1'b0};
    vt[3] = '{1'b1, 32'd7,        32'd9,         3'b000, 32'd16,       1'b0};
    vt[4] = '{1'b0, 32'h0000FF00, 32'h00000FF0,  3'b011, 32'h0000FFF0, 1'b0};
    vt[5] = '{1'b1, 32'd1,        32'd31,        3'b100, 32'h80000000, 1'b0};
    vt[6] = '{1'b0, 32'h80000000, 32'd40,        3'b101, 32'hFFFFFFFF, 1'b0};
    vt[7] = '{1'b1, 32'd5,        32'd6,         3'b110, 32'd0,        1'b1};
    vt[8] = '{1'b0, 32'd0,        32'd1,         3'b001, 32'hFFFFFFFF, 1'b0};

    // Reset with both requesters already valid (contention payloads).
    drive(1'b0, 32'd1,   32'd1,   3'b000, 1'b1);
    drive(1'b1, 32'hF0, 32'h3C, 3'b010, 1'b1);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    tick();
    rst_n = 1'b1;

    // Contention: both stay valid, grants must alternate starting with requester 0.
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      got = ((acc0_cnt + acc1_cnt) >= 4);
    end
    if (!got) note_fail("contention_accept_timeout");
    drive(1'b0, 32'd0, 32'd0, 3'b000, 1'b0);
    drive(1'b1, 32'd0, 32'd0, 3'b000, 1'b0);
    wait_rsp(4);
    chk("rr_count", 32'(id_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < id_log.size(); k++)
      chk("rr_order", 32'(id_log[k]), 32'(k % 2));

    // Table of single-requester operations.
    for (int k = 0; k < 9; k++) begin
      r0 = rsp_cnt;
      drive(vt[k].id, vt[k].a, vt[k].b, vt[k].op, 1'b1);
      wait_acc(vt[k].id);
      drive(vt[k].id, 32'd0, 32'd0, 3'b000, 1'b0);
      wait_rsp(r0 + 1);
      chk("vec_id", 32'(last_id), 32'(vt[k].id));
      chk("vec_data", last_data, vt[k].exp_data);
      chk("vec_err", 32'(last_err), 32'(vt[k].exp_err));
    end

    // Backpressure: hold RESP for 5 cycles while requester 1 waits.
    r0 = rsp_cnt;
    rsp_ready = 1'b0;
    drive(1'b0, 32'd10, 32'd4, 3'b000, 1'b1);
    wait_acc(1'b0);
    drive(1'b0, 32'd0, 32'd0, 3'b000, 1'b0);
    drive(1'b1, 32'd3, 32'd3, 3'b001, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_req1_ready", 32'(req1_ready), 32'd0);
      chk("bp_data", rsp_data, 32'd14);
      tick();
    end
    rsp_ready = 1'b1;
    wait_acc(1'b1);
    chk("bp_accept_after_rsp", 32'(acc1_cyc), 32'(rsp_cyc + 1));
    drive(1'b1, 32'd0, 32'd0, 3'b000, 1'b0);
    wait_rsp(r0 + 2);

    // Reset during EXEC: op is discarded, outputs drop at once, ptr returns to 0.
    drive(1'b0, 32'd100, 32'd1, 3'b000, 1'b1);
    wait_acc(1'b0);
    drive(1'b0, 32'd0, 32'd0, 3'b000, 1'b0);
    drive(1'b1, 32'd8, 32'd8, 3'b000, 1'b1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    sb.delete();
    drive(1'b1, 32'd0, 32'd0, 3'b000, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    r0 = rsp_cnt;
    for (int i = 0; i < 4; i++) tick();
    chk("no_rsp_after_rst", 32'(rsp_cnt), 32'(r0));
    chk("idle_after_rst", 32'(busy), 32'd0);
    a0 = acc0_cnt;
    tot = acc0_cnt + acc1_cnt;
    drive(1'b0, 32'd9, 32'd4, 3'b001, 1'b1);
    drive(1'b1, 32'd2, 32'd2, 3'b000, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      got = ((acc0_cnt + acc1_cnt) != tot);
    end
    if (!got) note_fail("post_rst_accept_timeout");
    chk("post_rst_ptr0_grant", 32'(acc0_cnt - a0), 32'd1);
    drive(1'b0, 32'd0, 32'd0, 3'b000, 1'b0);
    wait_acc(1'b1);
    drive(1'b1, 32'd0, 32'd0, 3'b000, 1'b0);
    wait_rsp(r0 + 2);
    chk("post_rst_last_id", 32'(last_id), 32'd1);
    chk("post_rst_last_data", last_data, 32'd4);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
